bram_burst_reader: RTL

Read-side controller for the 16 x 8 block RAM: on a start command it sweeps a contiguous, wrap-around address range through the BRAM read port. Each word is presented on a valid/ready output stream. The controller keeps a running sum of the accepted words with a sticky overflow flag. It sits between the BRAM port and downstream consumers, complementing the write/accumulate path that fills the memory.

---
 rtl/bram_burst_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bram_burst_reader.sv
// rtl/bram_burst_reader.sv - BRAM burst read controller with valid/ready output stream and running sum
module bram_burst_reader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int SUM_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [SUM_W-1:0]  sum,
    output logic              sum_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    // Index of the WAIT cycle whose closing edge sees valid douta.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_count;
    logic [1:0]        r_wait;
    logic              r_ena;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_out_data;
    logic [SUM_W-1:0]  r_sum;
    logic              r_sum_ovf;

    logic              w_last;
    logic [ADDR_W-1:0] w_count_nxt;
    logic [SUM_W:0]    w_sum_ext;

    assign w_last      = (r_count == r_len);
    assign w_count_nxt = r_count + 1'b1;
    // One extra bit catches the carry out of the SUM_W-bit accumulator.
    assign w_sum_ext   = {1'b0, r_sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, r_out_data};

    // State register; reset drops any burst and in-flight read at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_RD;
            S_RD:      w_next = S_WAIT;
            S_WAIT:    if (r_wait == WAIT_LAST) w_next = S_PRESENT;
            S_PRESENT: if (out_ready) w_next = w_last ? S_DONE : S_RD;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: command latch, BRAM address/enable, read capture and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_wait     <= '0;
            r_ena      <= 1'b0;
            r_addra    <= '0;
            r_out_data <= '0;
            r_sum      <= '0;
            r_sum_ovf  <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_len     <= len;
                        r_count   <= '0;
                        r_sum     <= '0;
                        r_sum_ovf <= 1'b0;
                        r_ena     <= 1'b1;
                        r_addra   <= base_addr;
                    end
                end
                S_RD: begin
                    r_wait <= '0;
                end
                S_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (r_wait == WAIT_LAST) r_out_data <= douta;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        r_sum     <= w_sum_ext[SUM_W-1:0];
                        r_sum_ovf <= r_sum_ovf | w_sum_ext[SUM_W];
                        if (!w_last) begin
                            // Address wraps naturally at 2^ADDR_W.
                            r_count <= w_count_nxt;
                            r_ena   <= 1'b1;
                            r_addra <= r_base + w_count_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RD) || (r_state == S_WAIT) || (r_state == S_PRESENT);
    assign done      = (r_state == S_DONE);
    assign ena       = r_ena;
    assign wea       = 1'b0;
    assign addra     = r_addra;
    assign out_data  = r_out_data;
    assign out_valid = (r_state == S_PRESENT);
    assign out_last  = (r_state == S_PRESENT) && w_last;
    assign sum       = r_sum;
    assign sum_ovf   = r_sum_ovf;

endmodule
